mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 16: data and address width in bits.
REQ-002 Parameter MEM_LAT, default 1, range 1..7: memory read latency in cycles, from strobe to valid dataFromMem.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req0/req1  in  1 each  access request, port 0 = processor, port 1 = loader/IO.
REQ-006 we0/we1  in  1 each  1 = write, 0 = read; valid while req high.
REQ-007 adr0/adr1, wdata0/wdata1  in  WIDTH each  address and write data; valid while req high.
REQ-008 lock0/lock1  in  1 each  owner keeps grant for back-to-back accesses.
REQ-009 ack0/ack1  out  1 each  one-cycle access-complete pulse.
REQ-010 rdata0/rdata1  out  WIDTH each  read data; valid with ack; held until next ack to same port.
REQ-011 memRead, memWrite  out  1 each  memory strobes.
REQ-012 adrToMem, dataToMem  out  WIDTH each  memory address and write data.
REQ-013 dataFromMem  in  WIDTH  memory read data.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 owner  out  1  index of the port holding or last holding the grant.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-017 IDLE: if any req is high, pick a winner, latch its we/adr/wdata, and go to ISSUE; else stay in IDLE.
REQ-018 ISSUE: drive adrToMem and dataToMem for exactly one cycle, with memWrite = we or memRead = !we; next state is WAIT for a read or RESP for a write.
REQ-019 WAIT: a 3-bit counter counts MEM_LAT cycles; on expiry capture dataFromMem into the winner's rdata and go to RESP.
REQ-020 RESP: pulse the winner's ack for one cycle; go to ISSUE for the same owner if that owner's lock and req are high, else go to IDLE.
REQ-021 Latency: write ack 2 cycles after the req is sampled in IDLE; read ack 2+MEM_LAT cycles after.
REQ-022 Requester handshake: the requester samples ack at the clock edge and drops req before the next IDLE sample; a req still high in IDLE is a new request.
REQ-023 Strobes are never both high; exactly one strobe pulse per access.
REQ-024 Simultaneous req0 and req1 in IDLE are resolved per REQ-030/031; the loser's req is held, not dropped.
REQ-025 A request arriving while busy waits; non-owner inputs are ignored until IDLE.
REQ-026 A lock on the non-owner port has no effect.
REQ-027 A req deasserted before it is granted is a legal cancel: no access is made and no ack is given.

Reset
REQ-028 With reset low: state IDLE, counter 0, all strobes and acks 0, adrToMem/dataToMem/rdata0/rdata1 = 0, owner = 1, busy = 0.
REQ-029 Reset mid-access aborts the access at once with no ack; the in-flight strobe is dropped in the same cycle (asynchronous).

Configuration
REQ-030 With MEM_ARB_RR_EN defined: round-robin; on a tie the port other than owner wins; owner updates at each grant.
REQ-031 Without MEM_ARB_RR_EN: fixed priority; port 0 wins every tie; owner still reports the granted port.

Structure
REQ-032 Package mem_arb_pkg holds the state enum, the port index constants PORT_CPU = 0 and PORT_AUX = 1, and the counter width constant.
REQ-033 One combinational sub-module, mem_arb_pick, takes req0, req1 and owner and returns the winner index; macro-dependent logic lives only there.

Verification
REQ-034 Single write: req0 = 1, we0 = 1, adr0 = 0x0010, wdata0 = 0xBEEF -> memWrite for 1 cycle with adrToMem = 0x0010 and dataToMem = 0xBEEF, ack0 2 cycles after the IDLE sample.
REQ-035 Read with MEM_LAT = 3: req1 read of 0x0020, memory returns 0x1234 -> memRead for 1 cycle, ack1 5 cycles after the sample, rdata1 = 0x1234.
REQ-036 Tie, both ports reading, repeated 4 times: with MEM_ARB_RR_EN grant order 0,1,0,1 (from owner = 1 after reset); without it 0,0,0,0 while req0 is re-asserted.
REQ-037 Lock burst: lock0 = 1 for 3 reads at 0x0000..0x0002 while req1 is high -> 3 consecutive port-0 accesses with no IDLE between them, then port 1 is served.
REQ-038 Reset low during WAIT -> strobes 0 immediately, no ack, state IDLE, rdata unchanged at 0; the first access after release completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

   localparam int unsigned CNT_W = 3;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_AUX = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arbState_e;

endpackage

// File: rtl/mem_arb_if.sv
// Requester and memory-side signal bundle of the two-port memory arbiter.
interface mem_arb_if #(
   parameter int unsigned WIDTH = 16
);

   logic             req0, req1;
   logic             we0, we1;
   logic             lock0, lock1;
   logic [WIDTH-1:0] adr0, adr1;
   logic [WIDTH-1:0] wdata0, wdata1;
   logic             ack0, ack1;
   logic [WIDTH-1:0] rdata0, rdata1;
   logic             memRead, memWrite;
   logic [WIDTH-1:0] adrToMem, dataToMem;
   logic [WIDTH-1:0] dataFromMem;
   logic             busy;
   logic             owner;

   // Environment side: requesters plus the memory returning read data
   modport master (
      output req0, req1, we0, we1, lock0, lock1,
      output adr0, adr1, wdata0, wdata1, dataFromMem,
      input  ack0, ack1, rdata0, rdata1,
      input  memRead, memWrite, adrToMem, dataToMem, busy, owner
   );

   modport slave (
      input  req0, req1, we0, we1, lock0, lock1,
      input  adr0, adr1, wdata0, wdata1, dataFromMem,
      output ack0, ack1, rdata0, rdata1,
      output memRead, memWrite, adrToMem, dataToMem, busy, owner
   );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner selection for the memory arbiter.
// MEM_ARB_RR_EN selects round-robin; otherwise port 0 has fixed priority.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic owner,
   output logic winner_c
);

`ifdef MEM_ARB_RR_EN
   // On a tie the port that did not hold the last grant wins
   always_comb begin
      winner_c = owner;
      if (req0 && req1) begin
         winner_c = ~owner;
      end else if (req0) begin
         winner_c = PORT_CPU;
      end else if (req1) begin
         winner_c = PORT_AUX;
      end
   end
`else
   always_comb begin
      winner_c = owner;
      if (req0) begin
         winner_c = PORT_CPU;
      end else if (req1) begin
         winner_c = PORT_AUX;
      end
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: IDLE -> ISSUE -> (WAIT) -> RESP, all outputs registered.
// Arbitration policy is selected by MEM_ARB_RR_EN inside mem_arb_pick.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic     clk,
   input  logic     reset,
   mem_arb_if.slave bus
);

   arbState_e        state, stateD;
   logic [CNT_W-1:0] cnt, cntD;
   logic             ownerQ, ownerD;
   logic             winner;
   logic             grant, grantPort, grantWe, ownerCont;
   logic             memReadQ, memReadD, memWriteQ, memWriteD;
   logic             ack0Q, ack0D, ack1Q, ack1D;
   logic             busyQ;
   logic [WIDTH-1:0] adrQ, adrD, dataQ, dataD;
   logic [WIDTH-1:0] rdata0Q, rdata0D, rdata1Q, rdata1D;

   mem_arb_pick uPick (
      .req0     (bus.req0),
      .req1     (bus.req1),
      .owner    (ownerQ),
      .winner_c (winner)
   );

   // Next state and next registered outputs
   always_comb begin
      stateD    = state;
      cntD      = cnt;
      ownerD    = ownerQ;
      memReadD  = 1'b0;
      memWriteD = 1'b0;
      adrD      = '0;
      dataD     = '0;
      rdata0D   = rdata0Q;
      rdata1D   = rdata1Q;
      grant     = 1'b0;
      grantPort = winner;
      grantWe   = 1'b0;
      ownerCont = (ownerQ == PORT_AUX) ? (bus.lock1 && bus.req1)
                                       : (bus.lock0 && bus.req0);

      unique case (state)
         IDLE: begin
            grant = bus.req0 || bus.req1;
         end
         ISSUE: begin
            // memWriteQ is the latched we of the access being issued
            stateD = memWriteQ ? RESP : WAIT;
            cntD   = '0;
         end
         WAIT: begin
            if (cnt == CNT_W'(MEM_LAT - 1)) begin
               stateD = RESP;
               if (ownerQ == PORT_AUX) rdata1D = bus.dataFromMem;
               else                    rdata0D = bus.dataFromMem;
            end else begin
               cntD = cnt + CNT_W'(1);
            end
         end
         RESP: begin
            grantPort = ownerQ;
            if (ownerCont) grant  = 1'b1;
            else           stateD = IDLE;
         end
      endcase

      if (grant) begin
         stateD    = ISSUE;
         ownerD    = grantPort;
         grantWe   = (grantPort == PORT_AUX) ? bus.we1 : bus.we0;
         memWriteD = grantWe;
         memReadD  = !grantWe;
         adrD      = (grantPort == PORT_AUX) ? bus.adr1   : bus.adr0;
         dataD     = (grantPort == PORT_AUX) ? bus.wdata1 : bus.wdata0;
      end

      ack0D = (stateD == RESP) && (ownerQ == PORT_CPU);
      ack1D = (stateD == RESP) && (ownerQ == PORT_AUX);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         ownerQ    <= PORT_AUX;
         memReadQ  <= 1'b0;
         memWriteQ <= 1'b0;
         ack0Q     <= 1'b0;
         ack1Q     <= 1'b0;
         busyQ     <= 1'b0;
         adrQ      <= '0;
         dataQ     <= '0;
         rdata0Q   <= '0;
         rdata1Q   <= '0;
      end else begin
         state     <= stateD;
         cnt       <= cntD;
         ownerQ    <= ownerD;
         memReadQ  <= memReadD;
         memWriteQ <= memWriteD;
         ack0Q     <= ack0D;
         ack1Q     <= ack1D;
         busyQ     <= (stateD != IDLE);
         adrQ      <= adrD;
         dataQ     <= dataD;
         rdata0Q   <= rdata0D;
         rdata1Q   <= rdata1D;
      end
   end

   assign bus.memRead   = memReadQ;
   assign bus.memWrite  = memWriteQ;
   assign bus.adrToMem  = adrQ;
   assign bus.dataToMem = dataQ;
   assign bus.ack0      = ack0Q;
   assign bus.ack1      = ack1Q;
   assign bus.rdata0    = rdata0Q;
   assign bus.rdata1    = rdata1Q;
   assign bus.busy      = busyQ;
   assign bus.owner     = ownerQ;

endmodule
